// File: rtl/alu_seq_if.sv
// Decode-side handshake bundle for alu_seq: opcode/shamt in, registered ALU control
// and shifter step strobes out. dbg_state mirrors the FSM state for observation.
interface alu_seq_if #(
    parameter int OPW = 4,
    parameter int SHW = 4
);
    logic           valid_in;
    logic           ready_out;
    logic [OPW-1:0] opcode;
    logic [SHW-1:0] shamt;
    logic           valid_out;
    logic [2:0]     aluop;
    logic           step_en;
    logic           step_dir;
    logic           busy;
    logic           err_out;
    logic [1:0]     dbg_state;

    modport master (
        output valid_in, opcode, shamt,
        input  ready_out, valid_out, aluop, step_en, step_dir, busy, err_out, dbg_state
    );

    modport slave (
        input  valid_in, opcode, shamt,
        output ready_out, valid_out, aluop, step_en, step_dir, busy, err_out, dbg_state
    );
endinterface

// File: rtl/alu_seq.sv
// Registered opcode-to-aluop decoder with a one-bit-per-cycle shift sequencer.
// Define ALU_SEQ_ERR_EN to flag opcodes >= 16 (aluop 3'b000, sticky err_out).
module alu_seq #(
    parameter int OPW = 4,
    parameter int SHW = 4
) (
    input logic       clk,
    input logic       reset,
    alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t         state;
    logic [SHW-1:0] cnt;
    logic [2:0]     aluop_q;
    logic           dir_q;
    logic           ready;
    logic           accept;
    logic           hi_nz;
    logic           is_shift;
    logic [2:0]     dec;

    // Handshake: an op transfers on a rising edge where valid_in && ready_out;
    // valid_in while ready_out is low is dropped, never queued.
    assign ready  = !reset && (state == IDLE || state == OUT);
    assign accept = bus.valid_in && ready;

    // Any set bit above bit 3 makes the opcode illegal.
    assign hi_nz    = (bus.opcode >> 4) != '0;
    assign is_shift = !hi_nz && (bus.opcode[3:1] == 3'b011);

    always_comb begin
        dec = 3'b010;
        if (!hi_nz) begin
            case (bus.opcode[3:0])
                4'b0001, 4'b1010, 4'b1011: dec = 3'b110;
                4'b0010:                   dec = 3'b000;
                4'b0011:                   dec = 3'b001;
                4'b1000:                   dec = 3'b111;
                4'b0110, 4'b0111:          dec = 3'b011;
                default:                   dec = 3'b010;
            endcase
        end
`ifdef ALU_SEQ_ERR_EN
        else begin
            dec = 3'b000;
        end
`endif
    end

`ifdef ALU_SEQ_ERR_EN
    logic err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            aluop_q <= 3'b010;
            dir_q   <= 1'b0;
`ifdef ALU_SEQ_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        aluop_q <= dec;
                        if (is_shift && bus.shamt != '0) begin
                            state <= SHIFT;
                            cnt   <= bus.shamt;
                            dir_q <= bus.opcode[0];
                        end else begin
                            state <= OUT;
                        end
`ifdef ALU_SEQ_ERR_EN
                        if (hi_nz) err_q <= 1'b1;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // Count lands on zero exactly as the sequence exits; it never wraps.
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) state <= OUT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_out = ready;
    assign bus.valid_out = (state == OUT);
    assign bus.aluop     = aluop_q;
    assign bus.step_en   = (state == SHIFT);
    assign bus.step_dir  = dir_q;
    assign bus.busy      = (state == SHIFT);
    assign bus.dbg_state = state;
`ifdef ALU_SEQ_ERR_EN
    assign bus.err_out   = err_q;
`else
    assign bus.err_out   = 1'b0;
`endif
endmodule
